// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer and HI/LO register pair.
// Results are computed at launch, held pending for a fixed busy period,
// then committed to HI/LO. Raises a D-stage stall while the unit is in use.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_isMD,
  output logic [31:0] E_mdOut,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        start,
  output logic        busy,
  output logic        D_stallMD
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_we;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;
  logic [CW-1:0] res_cycles;

  logic        op_is_arith;

  // Operation decode and combinational status outputs
  always_comb begin
    op_is_arith = (E_mdOp == OP_MULT)  || (E_mdOp == OP_MULTU) ||
                  (E_mdOp == OP_DIV)   || (E_mdOp == OP_DIVU);
    start       = op_is_arith && (state == IDLE);
    busy        = (state == RUN);
    D_stallMD   = D_isMD && (start || busy);
    if (E_mdOp == OP_MFHI)      E_mdOut = HI;
    else if (E_mdOp == OP_MFLO) E_mdOut = LO;
    else                        E_mdOut = '0;
  end

  // Result datapath: full product/quotient computed at launch time.
  // Divisor is forced to 1 on divide-by-zero so no X/trap reaches the
  // pending regs; res_we then suppresses the commit.
  always_comb begin
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_b;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic               s_ovf;

    prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    prod_u = {32'd0, E_A} * {32'd0, E_B};
    div_b  = (E_B == '0) ? 32'd1 : E_B;
    s_ovf  = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
    if (s_ovf) begin
      q_s = 32'sh8000_0000;
      r_s = '0;
    end else begin
      q_s = $signed(E_A) / $signed(div_b);
      r_s = $signed(E_A) % $signed(div_b);
    end

    res_hi     = '0;
    res_lo     = '0;
    res_we     = 1'b0;
    res_cycles = CW'(MULT_CYCLES);
    unique case (E_mdOp)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_we = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_we = 1'b1;
      end
      OP_DIV: begin
        res_hi     = r_s;
        res_lo     = q_s;
        res_we     = (E_B != '0);
        res_cycles = CW'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res_hi     = E_A % div_b;
        res_lo     = E_A / div_b;
        res_we     = (E_B != '0);
        res_cycles = CW'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  // Sequencer: launch, count down busy period, commit, and HI/LO moves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_we <= res_we;
            cnt     <= res_cycles;
            state   <= RUN;
          end else if (E_mdOp == OP_MTHI) begin
            HI <= E_A;
          end else if (E_mdOp == OP_MTLO) begin
            LO <= E_A;
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            if (pend_we) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
